// File: rtl/nco_mod_counter.sv
// Phase-accumulator tick generator driving a modulo-(MOD_MAX+1) up/down counter.
// Stages cascade by feeding carry into the next stage's en with num = 1.
module nco_mod_counter #(
   parameter int CNT_W   = 6,
   parameter int MOD_MAX = 59,
   parameter int NUM_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_W-1:0] num,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] out,
   output logic             tick,
   output logic             carry
);

   localparam logic [CNT_W-1:0] L_MOD_MAX = CNT_W'(MOD_MAX);

   logic [NUM_W-1:0] r_ph;
   logic [CNT_W-1:0] r_out;
   logic             r_tick;
   logic             r_carry;

   logic [NUM_W-1:0] w_period_m1;
   logic             w_period_done;
   logic [CNT_W-1:0] w_next_out;
   logic             w_wrap;
   logic [CNT_W-1:0] w_load_clamped;

   // num == 0 behaves as a one-cycle period; >= lets a shrinking num finish on the next edge
   assign w_period_m1    = (num == '0) ? '0 : num - NUM_W'(1);
   assign w_period_done  = (r_ph >= w_period_m1);
   assign w_load_clamped = (load_val > L_MOD_MAX) ? L_MOD_MAX : load_val;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      w_next_out = r_out;
      w_wrap     = 1'b0;
      if (up_dn) begin
         if (r_out == L_MOD_MAX) begin
            w_next_out = '0;
            w_wrap     = 1'b1;
         end else begin
            w_next_out = r_out + CNT_W'(1);
         end
      end else begin
         if (r_out == '0) begin
            w_next_out = L_MOD_MAX;
            w_wrap     = 1'b1;
         end else begin
            w_next_out = r_out - CNT_W'(1);
         end
      end
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ph    <= '0;
         r_out   <= '0;
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
      end else if (load) begin
         r_ph    <= '0;
         r_out   <= w_load_clamped;
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
      end else if (en) begin
         if (w_period_done) begin
            r_ph    <= '0;
            r_out   <= w_next_out;
            r_tick  <= 1'b1;
            r_carry <= w_wrap;
         end else begin
            r_ph    <= r_ph + NUM_W'(1);
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
         end
      end else begin
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
      end
   end

   assign out   = r_out;
   assign tick  = r_tick;
   assign carry = r_carry;

endmodule

// File: doc/nco_mod_counter.md
# nco_mod_counter

Parametrised successor to the team's NCO-plus-0..59-counter pair: a single-clock block with a phase accumulator that produces a one-cycle tick-enable every `num` enabled cycles and a modulo-(MOD_MAX+1) up/down counter advanced by that tick. No derived clock is generated; everything runs on `clk`. The block is intended as the building element of the clock/timer chain, where it is cascaded by feeding `carry` of one stage into `en` of the next with `num` = 1.

## Interface

Parameters:
- `CNT_W`, 6: counter width.
- `MOD_MAX`, 59: terminal count; must satisfy 1 ≤ MOD_MAX ≤ 2^CNT_W−1.
- `NUM_W`, 32: width of the period input and phase counter.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `num`  in  NUM_W  tick period in enabled cycles; 0 is treated as 1.
- `en`  in  1  advance enable for both the phase counter and the counter.
- `up_dn`  in  1  1 = count up, 0 = count down.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  CNT_W  load value.
- `out`  out  CNT_W  counter value, registered.
- `tick`  out  1  one-cycle pulse, registered, high in the cycle after each period completes.
- `carry`  out  1  one-cycle pulse, registered, high in the cycle after a wrap (up: MOD_MAX→0; down: 0→MOD_MAX).

## Operation

- Reset (`rst`=1 at an edge) forces `out`=0, `tick`=0, `carry`=0 and phase counter `ph`=0. Reset overrides `load` and `en`.
- Effective period: P = (num==0) ? 1 : num.
- On each edge with `en`=1 and no load or reset:
  - If `ph` ≥ P−1, the period is complete. `ph`←0, the counter advances, and `tick`←1.
  - Otherwise `ph`←`ph`+1 and `tick`←0.
- `ph` ≥ P−1 (not ==) makes the block robust to `num` shrinking mid-period: completion happens on the next enabled edge.
- Counter advance on a completed period:
  - Up: `out`==MOD_MAX → `out`←0, `carry`←1; else `out`+1.
  - Down: `out`==0 → `out`←MOD_MAX, `carry`←1; else `out`−1.
- `en`=0: `ph` and `out` hold; `tick` and `carry` go to 0 on that edge.
- `load`=1 (no reset): `out`←min(`load_val`, MOD_MAX) and `ph`←0, regardless of `en`. `tick`←0 and `carry`←0; a period completing on the same edge is discarded.
- `out` never exceeds MOD_MAX. All arithmetic is unsigned, with `ph` at NUM_W bits. The P−1 compare never underflows because P ≥ 1.
- `up_dn` is sampled only on edges where the counter advances. A direction change mid-period takes effect on the next advance.

## Timing

- With `en` held high from reset release, `out` first changes on the P-th edge. It changes every P edges thereafter.
- `tick` and `carry` rise on the same edge as the `out` update they accompany. They are high for exactly one cycle, coincident with the new `out` value.
- P=1: `out` advances and `tick`=1 on every enabled edge. In up mode, `carry` is high for one cycle out of every MOD_MAX+1.
- `num` changes take effect on the next edge. No restart of `ph` occurs unless P−1 ≤ `ph`.
- Reset asserted mid-period: outputs are 0 on the following cycle and the period restarts from `ph`=0 after release.
- Load-to-output latency is one edge. Reset-to-output latency is one edge.

## Test plan

- Reset, then `num`=4, `en`=1, `up_dn`=1: `out` steps 0→1 on edge 4, then every 4 edges. `tick` is high one cycle per step. At 59→0, `carry`=1 for one cycle (edge 240). No `carry` elsewhere.
- `num`=0, then `num`=1, `up_dn`=0, from `out`=0: first edge gives `out`=59 with `carry`=1 and `tick`=1. Then 58, 57, …, one step per cycle.
- `num`=10; after 6 enabled edges set `num`=3: completion on the next edge (`ph`=6 ≥ 2). Period is 3 thereafter.
- `load`=1 with `load_val`=63 on an edge where a period completes: `out`=59, `tick`=0, `carry`=0. The next step occurs P edges later.
- Toggle `en` low for 5 cycles mid-period with `num`=4: `out` and phase hold, `tick` stays 0, and the step is delayed exactly 5 cycles.
- Assert `rst` for one edge while `out`=30 and `ph`=2: next cycle `out`=0, `tick`=0, `carry`=0. The first step comes P edges after release. Cascade check with a second instance (`en`=carry, `num`=1): it increments once per 60 steps of the first instance.
